control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit.sv | 215 +++++++++++++++++++++
 tb/tb_control_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// Hardwired multi-cycle control unit: fetch (F0-F2) plus per-opcode execute (T3-T7).
// Outputs are decoded combinationally from the current state and IR.
module control_unit (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] IR,
    input  logic        mem_ready,
    output logic [31:0] enable,
    output logic [31:0] busSelect,
    output logic [3:0]  Control_Signals,
    output logic        MR_Read,
    output logic        mem_write,
    output logic        halted
);

    typedef enum logic [3:0] {
        StIdle, StF0, StF1, StF2, StT3, StT4, StT5, StT6, StT7, StHalt
    } state_e;

    localparam logic [4:0] OpLd   = 5'b00000;
    localparam logic [4:0] OpSt   = 5'b00010;
    localparam logic [4:0] OpAdd  = 5'b00011;
    localparam logic [4:0] OpSub  = 5'b00100;
    localparam logic [4:0] OpAnd  = 5'b00101;
    localparam logic [4:0] OpOr   = 5'b00110;
    localparam logic [4:0] OpAddi = 5'b01011;
    localparam logic [4:0] OpMul  = 5'b01111;
    localparam logic [4:0] OpDiv  = 5'b10000;
    localparam logic [4:0] OpMfhi = 5'b11000;
    localparam logic [4:0] OpMflo = 5'b11001;
    localparam logic [4:0] OpHalt = 5'b11011;

    localparam logic [3:0] AluAdd   = 4'd0;
    localparam logic [3:0] AluSub   = 4'd1;
    localparam logic [3:0] AluAnd   = 4'd2;
    localparam logic [3:0] AluOr    = 4'd3;
    localparam logic [3:0] AluMul   = 4'd6;
    localparam logic [3:0] AluDiv   = 4'd7;
    localparam logic [3:0] AluIncPc = 4'd10;

    localparam int unsigned EnHi  = 16;
    localparam int unsigned EnLo  = 17;
    localparam int unsigned EnPc  = 20;
    localparam int unsigned EnMdr = 21;
    localparam int unsigned EnIr  = 23;
    localparam int unsigned EnZ   = 24;
    localparam int unsigned EnMar = 25;
    localparam int unsigned EnY   = 27;

    localparam int unsigned BusHi  = 16;
    localparam int unsigned BusLo  = 17;
    localparam int unsigned BusZhi = 18;
    localparam int unsigned BusZlo = 19;
    localparam int unsigned BusPc  = 20;
    localparam int unsigned BusMdr = 21;
    localparam int unsigned BusC   = 23;

    state_e state_q, state_d;

    logic [4:0] opcode;
    logic [4:0] ra, rb, rc;
    logic       is_alu, is_addi, is_muldiv, is_ld, is_st, is_mfhi, is_mflo, is_halt;
    logic [3:0] alu_op;

    // Register fields are zero-extended to 5 bits to index the 32-bit strobe vectors.
    assign opcode = IR[31:27];
    assign ra     = {1'b0, IR[26:23]};
    assign rb     = {1'b0, IR[22:19]};
    assign rc     = {1'b0, IR[18:15]};

    always_comb begin
        is_alu    = (opcode == OpAdd) || (opcode == OpSub) ||
                    (opcode == OpAnd) || (opcode == OpOr);
        is_addi   = (opcode == OpAddi);
        is_muldiv = (opcode == OpMul) || (opcode == OpDiv);
        is_ld     = (opcode == OpLd);
        is_st     = (opcode == OpSt);
        is_mfhi   = (opcode == OpMfhi);
        is_mflo   = (opcode == OpMflo);
        is_halt   = (opcode == OpHalt);
        unique case (opcode)
            OpSub:   alu_op = AluSub;
            OpAnd:   alu_op = AluAnd;
            OpOr:    alu_op = AluOr;
            OpMul:   alu_op = AluMul;
            OpDiv:   alu_op = AluDiv;
            default: alu_op = AluAdd;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        enable          = '0;
        busSelect       = '0;
        Control_Signals = '0;
        MR_Read         = 1'b0;
        mem_write       = 1'b0;
        halted          = 1'b0;
        unique case (state_q)
            StIdle: state_d = StF0;
            StF0: begin
                busSelect[BusPc] = 1'b1;
                enable[EnMar]    = 1'b1;
                enable[EnZ]      = 1'b1;
                Control_Signals  = AluIncPc;
                state_d          = StF1;
            end
            StF1: begin
                busSelect[BusZlo] = 1'b1;
                enable[EnPc]      = 1'b1;
                MR_Read           = 1'b1;
                if (mem_ready) begin
                    enable[EnMdr] = 1'b1;
                    state_d       = StF2;
                end
            end
            StF2: begin
                busSelect[BusMdr] = 1'b1;
                enable[EnIr]      = 1'b1;
                state_d           = StT3;
            end
            StT3: begin
                state_d = StF0;
                if (is_alu || is_addi || is_ld || is_st) begin
                    busSelect[rb] = 1'b1;
                    enable[EnY]   = 1'b1;
                    state_d       = StT4;
                end else if (is_muldiv) begin
                    busSelect[ra] = 1'b1;
                    enable[EnY]   = 1'b1;
                    state_d       = StT4;
                end else if (is_mfhi || is_mflo) begin
                    busSelect[is_mfhi ? BusHi : BusLo] = 1'b1;
                    enable[ra] = 1'b1;
                end else if (is_halt) begin
                    state_d = StHalt;
                end
            end
            StT4: begin
                state_d = StT5;
                if (is_alu) begin
                    busSelect[rc]   = 1'b1;
                    Control_Signals = alu_op;
                    enable[EnZ]     = 1'b1;
                end else if (is_addi || is_ld || is_st) begin
                    busSelect[BusC] = 1'b1;
                    Control_Signals = AluAdd;
                    enable[EnZ]     = 1'b1;
                end else if (is_muldiv) begin
                    busSelect[rb]   = 1'b1;
                    Control_Signals = alu_op;
                    enable[EnZ]     = 1'b1;
                end else begin
                    state_d = StF0;
                end
            end
            StT5: begin
                state_d = StF0;
                if (is_alu || is_addi) begin
                    busSelect[BusZlo] = 1'b1;
                    enable[ra]        = 1'b1;
                end else if (is_muldiv) begin
                    busSelect[BusZlo] = 1'b1;
                    enable[EnLo]      = 1'b1;
                    state_d           = StT6;
                end else if (is_ld || is_st) begin
                    busSelect[BusZlo] = 1'b1;
                    enable[EnMar]     = 1'b1;
                    state_d           = StT6;
                end
            end
            StT6: begin
                state_d = StF0;
                if (is_muldiv) begin
                    busSelect[BusZhi] = 1'b1;
                    enable[EnHi]      = 1'b1;
                end else if (is_ld) begin
                    MR_Read = 1'b1;
                    state_d = StT6;
                    if (mem_ready) begin
                        enable[EnMdr] = 1'b1;
                        state_d       = StT7;
                    end
                end else if (is_st) begin
                    busSelect[ra] = 1'b1;
                    enable[EnMdr] = 1'b1;
                    state_d       = StT7;
                end
            end
            StT7: begin
                state_d = StF0;
                if (is_ld) begin
                    busSelect[BusMdr] = 1'b1;
                    enable[ra]        = 1'b1;
                end else if (is_st) begin
                    mem_write = 1'b1;
                    if (!mem_ready) begin
                        state_d = StT7;
                    end
                end
            end
            StHalt: halted = 1'b1;
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic [31:0] IR = '0;
    logic        mem_ready = 1'b0;
    logic [31:0] enable;
    logic [31:0] busSelect;
    logic [3:0]  Control_Signals;
    logic        MR_Read;
    logic        mem_write;
    logic        halted;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [31:0] en;
        logic [31:0] bus;
        logic [3:0]  cs;
        logic        mr;
        logic        mw;
        logic        h;
    } exp_t;

    exp_t sb_q[$];

    localparam logic [31:0] EnF0  = 32'h0300_0000; // MAR + Z
    localparam logic [31:0] BusPc = 32'h0010_0000;
    localparam logic [31:0] EnPc  = 32'h0010_0000;
    localparam logic [31:0] EnMdr = 32'h0020_0000;
    localparam logic [31:0] BusZl = 32'h0008_0000;
    localparam logic [31:0] BusZh = 32'h0004_0000;
    localparam logic [31:0] BusMd = 32'h0020_0000;
    localparam logic [31:0] EnIr  = 32'h0080_0000;
    localparam logic [31:0] EnY   = 32'h0800_0000;
    localparam logic [31:0] EnZ   = 32'h0100_0000;
    localparam logic [31:0] EnMar = 32'h0200_0000;
    localparam logic [31:0] BusC  = 32'h0080_0000;

    control_unit dut (
        .clk             (clk),
        .clr             (clr),
        .IR              (IR),
        .mem_ready       (mem_ready),
        .enable          (enable),
        .busSelect       (busSelect),
        .Control_Signals (Control_Signals),
        .MR_Read         (MR_Read),
        .mem_write       (mem_write),
        .halted          (halted)
    );

    always #5 clk = ~clk;

    // Monitor: checks read/write exclusivity every cycle and pops one expectation if queued.
    always @(negedge clk) begin
        exp_t e;
        checks++;
        if (MR_Read && mem_write) begin
            errors++;
            $display("FAIL rw_exclusive t=%0t got MR_Read=%b mem_write=%b want not both",
                     $time, MR_Read, mem_write);
        end
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            if (enable !== e.en || busSelect !== e.bus || Control_Signals !== e.cs ||
                MR_Read !== e.mr || mem_write !== e.mw || halted !== e.h) begin
                errors++;
                $display({"FAIL %s t=%0t got en=%h bus=%h cs=%0d mr=%b mw=%b h=%b ",
                          "want en=%h bus=%h cs=%0d mr=%b mw=%b h=%b"},
                         e.name, $time, enable, busSelect, Control_Signals, MR_Read,
                         mem_write, halted, e.en, e.bus, e.cs, e.mr, e.mw, e.h);
            end
        end
    end

    task automatic exp_cycle(input string name, input logic [31:0] en, input logic [31:0] bus,
                             input logic [3:0] cs, input logic mr, input logic mw,
                             input logic h);
        exp_t e;
        e.name = name;
        e.en   = en;
        e.bus  = bus;
        e.cs   = cs;
        e.mr   = mr;
        e.mw   = mw;
        e.h    = h;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input int waits);
        mem_ready = 1'b1; // ignored outside wait states
        exp_cycle("F0", EnF0, BusPc, 4'd10, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < waits; i++) begin
            mem_ready = 1'b0;
            exp_cycle("F1_wait", EnPc, BusZl, 4'd0, 1'b1, 1'b0, 1'b0);
        end
        mem_ready = 1'b1;
        exp_cycle("F1", EnPc | EnMdr, BusZl, 4'd0, 1'b1, 1'b0, 1'b0);
        exp_cycle("F2", EnIr, BusMd, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1);
    end

    initial begin
        #1 clr = 1'b1;
        @(posedge clk);
        #1;
        exp_cycle("reset", 32'h0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0);
        clr = 1'b0;
        exp_cycle("idle", 32'h0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0);

        // add R1,R2,R3
        IR = 32'h1891_8000;
        fetch(0);
        exp_cycle("add_T3", EnY, 32'h4, 4'd0, 1'b0, 1'b0, 1'b0);
        exp_cycle("add_T4", EnZ, 32'h8, 4'd0, 1'b0, 1'b0, 1'b0);
        exp_cycle("add_T5", 32'h2, BusZl, 4'd0, 1'b0, 1'b0, 1'b0);

        // sub R7,R8,R9 with one fetch wait
        IR = 32'h23C4_8000;
        fetch(1);
        exp_cycle("sub_T3", EnY, 32'h100, 4'd0, 1'b0, 1'b0, 1'b0);
        exp_cycle("sub_T4", EnZ, 32'h200, 4'd1, 1'b0, 1'b0, 1'b0);
        exp_cycle("sub_T5", 32'h80, BusZl, 4'd0, 1'b0, 1'b0, 1'b0);

        // addi R3,R2,5
        IR = 32'h5990_0005;
        fetch(0);
        exp_cycle("addi_T3", EnY, 32'h4, 4'd0, 1'b0, 1'b0, 1'b0);
        exp_cycle("addi_T4", EnZ, BusC, 4'd0, 1'b0, 1'b0, 1'b0);
        exp_cycle("addi_T5", 32'h8, BusZl, 4'd0, 1'b0, 1'b0, 1'b0);

        // mul R0,R0
        IR = 32'h7800_0000;
        fetch(0);
        exp_cycle("mul_T3", EnY, 32'h1, 4'd0, 1'b0, 1'b0, 1'b0);
        exp_cycle("mul_T4", EnZ, 32'h1, 4'd6, 1'b0, 1'b0, 1'b0);
        exp_cycle("mul_T5", 32'h0002_0000, BusZl, 4'd0, 1'b0, 1'b0, 1'b0);
        exp_cycle("mul_T6", 32'h0001_0000, BusZh, 4'd0, 1'b0, 1'b0, 1'b0);

        // mflo R6
        IR = 32'hCB00_0000;
        fetch(0);
        exp_cycle("mflo_T3", 32'h40, 32'h0002_0000, 4'd0, 1'b0, 1'b0, 1'b0);

        // ld R4,0x10(R2) with three memory stalls in T6
        IR = 32'h0210_0010;
        fetch(0);
        exp_cycle("ld_T3", EnY, 32'h4, 4'd0, 1'b0, 1'b0, 1'b0);
        exp_cycle("ld_T4", EnZ, BusC, 4'd0, 1'b0, 1'b0, 1'b0);
        exp_cycle("ld_T5", EnMar, BusZl, 4'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            mem_ready = 1'b0;
            exp_cycle("ld_T6_wait", 32'h0, 32'h0, 4'd0, 1'b1, 1'b0, 1'b0);
        end
        mem_ready = 1'b1;
        exp_cycle("ld_T6", EnMdr, 32'h0, 4'd0, 1'b1, 1'b0, 1'b0);
        exp_cycle("ld_T7", 32'h10, BusMd, 4'd0, 1'b0, 1'b0, 1'b0);

        // st R5,0(R0) with two write stalls in T7
        IR = 32'h1280_0000;
        fetch(0);
        exp_cycle("st_T3", EnY, 32'h1, 4'd0, 1'b0, 1'b0, 1'b0);
        exp_cycle("st_T4", EnZ, BusC, 4'd0, 1'b0, 1'b0, 1'b0);
        exp_cycle("st_T5", EnMar, BusZl, 4'd0, 1'b0, 1'b0, 1'b0);
        exp_cycle("st_T6", EnMdr, 32'h20, 4'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            mem_ready = 1'b0;
            exp_cycle("st_T7_wait", 32'h0, 32'h0, 4'd0, 1'b0, 1'b1, 1'b0);
        end
        mem_ready = 1'b1;
        exp_cycle("st_T7", 32'h0, 32'h0, 4'd0, 1'b0, 1'b1, 1'b0);

        // unknown opcode behaves as nop
        IR = 32'hF800_0000;
        fetch(0);
        exp_cycle("unk_T3", 32'h0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0);

        // clr during an F1 memory wait
        exp_cycle("F0_pre_clr", EnF0, BusPc, 4'd10, 1'b0, 1'b0, 1'b0);
        mem_ready = 1'b0;
        exp_cycle("F1_pre_clr", EnPc, BusZl, 4'd0, 1'b1, 1'b0, 1'b0);
        clr = 1'b1;
        exp_cycle("clr_in_F1", 32'h0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0);
        clr = 1'b0;
        exp_cycle("idle_after_F1", 32'h0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0);

        // halt, held across 20 cycles with mem_ready toggling
        IR = 32'hD800_0000;
        fetch(0);
        exp_cycle("halt_T3", 32'h0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            mem_ready = i[0];
            exp_cycle("halted", 32'h0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b1);
        end
        clr = 1'b1;
        exp_cycle("clr_in_halt", 32'h0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0);
        clr = 1'b0;
        exp_cycle("idle_after_halt", 32'h0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0);
        exp_cycle("F0_after_halt", EnF0, BusPc, 4'd10, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) begin
            @(negedge clk);
        end
        if (sb_q.size() > 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
